// File: rtl/seg_scan6_if.sv
// Display-side bundle for seg_scan6: six BCD digits and set flags in, multiplexed
// digit enables, segments, decimal point and frame strobe out.
interface seg_scan6_if;
    logic [3:0] hour_H;
    logic [3:0] hour_L;
    logic [3:0] min_H;
    logic [3:0] min_L;
    logic [3:0] sec_H;
    logic [3:0] sec_L;
    logic       set_H;
    logic       set_L;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    modport master (
        output hour_H, hour_L, min_H, min_L, sec_H, sec_L, set_H, set_L,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  hour_H, hour_L, min_H, min_L, sec_H, sec_L, set_H, set_L,
        output an, seg, dp, frame_tick
    );
endinterface

// File: rtl/seg_scan6.sv
// 6-digit common-anode 7-segment scanner (HH.MM.SS) with per-frame snapshot and hour blink.
// Optional macro SEG_SCAN_LZB_EN blanks the hour tens digit when it is zero.
//
// state | meaning
// DIG0  | sec_L slot   (an bit 0)
// DIG1  | sec_H slot   (an bit 1)
// DIG2  | min_L slot   (an bit 2, dp lit)
// DIG3  | min_H slot   (an bit 3)
// DIG4  | hour_L slot  (an bit 4, dp lit, blinks with set_L)
// DIG5  | hour_H slot  (an bit 5, blinks with set_H)
module seg_scan6 #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       clr_n,
    seg_scan6_if.slave io_bus
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    typedef enum logic [2:0] {
        DIG0 = 3'd0,
        DIG1 = 3'd1,
        DIG2 = 3'd2,
        DIG3 = 3'd3,
        DIG4 = 3'd4,
        DIG5 = 3'd5
    } digit_e;

    digit_e          r_digit;
    digit_e          w_digit_nxt;
    logic [PW-1:0]   r_presc;
    logic [BW-1:0]   r_blink_cnt;
    logic            r_blink_phase;
    logic [5:0][3:0] r_snap;

    logic [5:0]      r_an;
    logic [6:0]      r_seg;
    logic            r_dp;
    logic            r_frame_tick;

    logic            w_slot_end;
    logic            w_frame_start;
    logic [3:0]      w_digit_val;
    logic [5:0]      w_an;
    logic [6:0]      w_seg;
    logic            w_dp;
    logic            w_blank;

    function automatic logic [6:0] f_seg7(input logic [3:0] i_bcd);
        logic [6:0] v_pat;
        case (i_bcd)
            4'd0:    v_pat = 7'b1000000;
            4'd1:    v_pat = 7'b1111001;
            4'd2:    v_pat = 7'b0100100;
            4'd3:    v_pat = 7'b0110000;
            4'd4:    v_pat = 7'b0011001;
            4'd5:    v_pat = 7'b0010010;
            4'd6:    v_pat = 7'b0000010;
            4'd7:    v_pat = 7'b1111000;
            4'd8:    v_pat = 7'b0000000;
            4'd9:    v_pat = 7'b0010000;
            default: v_pat = 7'b0111111;
        endcase
        return v_pat;
    endfunction

    assign w_slot_end    = (r_presc == PRESC_LAST);
    assign w_frame_start = w_slot_end && (r_digit == DIG5);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_presc <= '0;
        end else if (w_slot_end) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_digit <= DIG0;
        end else begin
            r_digit <= w_digit_nxt;
        end
    end

    always_comb begin
        w_digit_nxt = r_digit;
        if (w_slot_end) begin
            case (r_digit)
                DIG0:    w_digit_nxt = DIG1;
                DIG1:    w_digit_nxt = DIG2;
                DIG2:    w_digit_nxt = DIG3;
                DIG3:    w_digit_nxt = DIG4;
                DIG4:    w_digit_nxt = DIG5;
                DIG5:    w_digit_nxt = DIG0;
                default: w_digit_nxt = DIG0;
            endcase
        end
    end

    // Whole-frame snapshot keeps a digit rollover from tearing across the display.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_snap <= '0;
        end else if (w_frame_start) begin
            r_snap <= {io_bus.hour_H, io_bus.hour_L, io_bus.min_H,
                       io_bus.min_L,  io_bus.sec_H,  io_bus.sec_L};
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_frame_start) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + BW'(1);
            end
        end
    end

    always_comb begin
        w_digit_val = 4'h0;
        case (r_digit)
            DIG0:    w_digit_val = r_snap[0];
            DIG1:    w_digit_val = r_snap[1];
            DIG2:    w_digit_val = r_snap[2];
            DIG3:    w_digit_val = r_snap[3];
            DIG4:    w_digit_val = r_snap[4];
            DIG5:    w_digit_val = r_snap[5];
            default: w_digit_val = 4'h0;
        endcase
    end

    // Set flags are taken live so blinking reacts immediately to the setting buttons.
    assign w_blank = r_blink_phase &&
                     (((r_digit == DIG5) && io_bus.set_H) ||
                      ((r_digit == DIG4) && io_bus.set_L));

    always_comb begin
        w_an  = 6'h3F;
        w_seg = f_seg7(w_digit_val);
        w_dp  = ~((r_digit == DIG2) || (r_digit == DIG4));
        if (r_presc != '0) begin
            w_an = ~(6'b000001 << r_digit);
        end
`ifdef SEG_SCAN_LZB_EN
        if ((r_digit == DIG5) && (r_snap[5] == 4'h0)) begin
            w_seg = 7'h7F;
        end
`endif
        if (w_blank) begin
            w_seg = 7'h7F;
            w_dp  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_an         <= 6'h3F;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_an         <= w_an;
            r_seg        <= w_seg;
            r_dp         <= w_dp;
            r_frame_tick <= w_frame_start;
        end
    end

    assign io_bus.an         = r_an;
    assign io_bus.seg        = r_seg;
    assign io_bus.dp         = r_dp;
    assign io_bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan6.sv
// Self-checking bench for seg_scan6 with SCAN_DIV=4, BLINK_FRAMES=2; expected outputs come
// from an elapsed-cycle model (slot, digit and frame derived arithmetically from edge count).
module tb_seg_scan6;

    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = SCAN_DIV * 6;

    logic clk = 1'b0;
    logic clr_n;

    seg_scan6_if ifc ();

    seg_scan6 #(
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .io_bus (ifc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;

    logic [3:0] m_snap [6];
    logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [5:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_ft;

    // Advance one clock; expected outputs after edge k reflect the scan position reached
    // after k-1 edges since reset release.
    task automatic adv();
        logic [3:0] in_now [6];
        logic       sh, sl;
        int         s, presc, idx, f, phase;
        logic [3:0] d;
        in_now[0] = ifc.sec_L;  in_now[1] = ifc.sec_H;
        in_now[2] = ifc.min_L;  in_now[3] = ifc.min_H;
        in_now[4] = ifc.hour_L; in_now[5] = ifc.hour_H;
        sh = ifc.set_H;
        sl = ifc.set_L;
        @(posedge clk);
        #1;
        k++;
        s     = k - 1;
        presc = s % SCAN_DIV;
        idx   = (s / SCAN_DIV) % 6;
        f     = s / FRAME;
        phase = (f / BLINK_FRAMES) % 2;
        exp_an  = (presc == 0) ? 6'h3F : ~(6'b000001 << idx);
        d       = m_snap[idx];
        exp_seg = (d <= 4'd9) ? pat[d] : 7'h3F;
        exp_dp  = (idx == 2 || idx == 4) ? 1'b0 : 1'b1;
`ifdef SEG_SCAN_LZB_EN
        if (idx == 5 && d == 4'd0) exp_seg = 7'h7F;
`endif
        if (phase == 1 && ((idx == 5 && sh) || (idx == 4 && sl))) begin
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
        end
        exp_ft = (k % FRAME == 0);
        if (k % FRAME == 0) m_snap = in_now;
    endtask

    task automatic set_inputs(input logic [3:0] hh, hl, mh, ml, sh, sl);
        ifc.hour_H = hh; ifc.hour_L = hl; ifc.min_H = mh;
        ifc.min_L  = ml; ifc.sec_H  = sh; ifc.sec_L = sl;
    endtask

    task automatic test_reset();
        clr_n = 1'b1;
        set_inputs(4'd2, 4'd3, 4'd5, 4'd9, 4'd0, 4'd7);
        ifc.set_H = 1'b0;
        ifc.set_L = 1'b0;
        #1 clr_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({ifc.an, ifc.seg, ifc.dp, ifc.frame_tick} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_hold got an=%h seg=%h dp=%b ft=%b need an=3f seg=7f dp=1 ft=0",
                         ifc.an, ifc.seg, ifc.dp, ifc.frame_tick);
            end
        end
        clr_n = 1'b1;
        k = 0;
        for (int i = 0; i < 6; i++) m_snap[i] = 4'h0;
    endtask

    task automatic test_first_frame();
        int   cnt      = 0;
        int   bad_zero = 0;
        logic skip;
        do begin
            adv();
            cnt++;
            n_checks++;
            if ({ifc.an, ifc.seg, ifc.dp, ifc.frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
                n_fail++;
                $display("FAIL first_frame k=%0d got an=%h seg=%h dp=%b ft=%b need an=%h seg=%h dp=%b ft=%b",
                         k, ifc.an, ifc.seg, ifc.dp, ifc.frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
            end
`ifdef SEG_SCAN_LZB_EN
            skip = (ifc.an == 6'h1F);
`else
            skip = 1'b0;
`endif
            if (ifc.an != 6'h3F && !skip && ifc.seg !== 7'h40) bad_zero++;
        end while (ifc.frame_tick !== 1'b1 && cnt < 100);
        n_checks++;
        if (cnt !== 24) begin
            n_fail++;
            $display("FAIL first_tick_latency got %0d clks need 24", cnt);
        end
        n_checks++;
        if (bad_zero !== 0) begin
            n_fail++;
            $display("FAIL first_frame_zeros got %0d non-zero digit cycles need 0", bad_zero);
        end
    endtask

    task automatic test_scan_pattern();
        logic [5:0] an_tab  [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
        logic [6:0] seg_tab [6] = '{7'h78, 7'h40, 7'h10, 7'h12, 7'h30, 7'h24};
        logic       dp_tab  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int j = 0; j < 6; j++) begin
            for (int c = 0; c < SCAN_DIV; c++) begin
                adv();
                n_checks++;
                if ({ifc.an, ifc.seg, ifc.dp, ifc.frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
                    n_fail++;
                    $display("FAIL scan_model k=%0d got an=%h seg=%h dp=%b ft=%b need an=%h seg=%h dp=%b ft=%b",
                             k, ifc.an, ifc.seg, ifc.dp, ifc.frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
                end
                n_checks++;
                if (c == 0) begin
                    if (ifc.an !== 6'h3F) begin
                        n_fail++;
                        $display("FAIL scan_gap slot=%0d got an=%h need 3f", j, ifc.an);
                    end
                end else if ({ifc.an, ifc.seg, ifc.dp} !== {an_tab[j], seg_tab[j], dp_tab[j]}) begin
                    n_fail++;
                    $display("FAIL scan_table slot=%0d got an=%h seg=%h dp=%b need an=%h seg=%h dp=%b",
                             j, ifc.an, ifc.seg, ifc.dp, an_tab[j], seg_tab[j], dp_tab[j]);
                end
            end
        end
    endtask

    task automatic test_snapshot_midframe();
        int cnt = 0;
        adv();
        adv();
        ifc.sec_L = 4'd8;
        adv();
        n_checks++;
        if ({ifc.an, ifc.seg} !== {6'h3E, 7'h78}) begin
            n_fail++;
            $display("FAIL snapshot_hold got an=%h seg=%h need an=3e seg=78", ifc.an, ifc.seg);
        end
        do begin
            adv();
            cnt++;
            n_checks++;
            if ({ifc.an, ifc.seg, ifc.dp, ifc.frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
                n_fail++;
                $display("FAIL snapshot_model k=%0d got an=%h seg=%h dp=%b ft=%b need an=%h seg=%h dp=%b ft=%b",
                         k, ifc.an, ifc.seg, ifc.dp, ifc.frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
            end
        end while (ifc.frame_tick !== 1'b1 && cnt < 100);
        n_checks++;
        if (cnt >= 100) begin
            n_fail++;
            $display("FAIL snapshot_tick_timeout got no frame_tick within %0d clks need one", cnt);
        end
        adv();
        adv();
        n_checks++;
        if ({ifc.an, ifc.seg} !== {6'h3E, 7'h00}) begin
            n_fail++;
            $display("FAIL snapshot_update got an=%h seg=%h need an=3e seg=00", ifc.an, ifc.seg);
        end
    endtask

    task automatic run_model(input int cycles, input string name);
        for (int i = 0; i < cycles; i++) begin
            adv();
            n_checks++;
            if ({ifc.an, ifc.seg, ifc.dp, ifc.frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
                n_fail++;
                $display("FAIL %s k=%0d got an=%h seg=%h dp=%b ft=%b need an=%h seg=%h dp=%b ft=%b",
                         name, k, ifc.an, ifc.seg, ifc.dp, ifc.frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
            end
        end
    endtask

    task automatic test_blink();
        int vis [8];
        ifc.hour_H = 4'd1;
        ifc.set_H  = 1'b1;
        run_model(FRAME * 8, "blink_set_H");
        ifc.set_L = 1'b1;
        run_model(FRAME * 6, "blink_set_both");
        ifc.set_H = 1'b0;
        ifc.set_L = 1'b0;
    endtask

    task automatic test_dash();
        ifc.min_H = 4'hC;
        run_model(FRAME * 2, "dash");
        n_checks++;
        if (m_snap[3] !== 4'hC) begin
            n_fail++;
            $display("FAIL dash_setup got model digit3=%h need c", m_snap[3]);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            set_inputs(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            ifc.set_H = 1'($urandom_range(0, 1));
            ifc.set_L = 1'($urandom_range(0, 1));
            run_model($urandom_range(5, 40), "random");
        end
        ifc.set_H = 1'b0;
        ifc.set_L = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int cnt = 0;
        while (!(((k / SCAN_DIV) % 6 == 3) && (k % SCAN_DIV == 2)) && cnt < 100) begin
            run_model(1, "pre_reset");
            cnt++;
        end
        #2 clr_n = 1'b0;
        #1;
        n_checks++;
        if ({ifc.an, ifc.seg, ifc.dp, ifc.frame_tick} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset got an=%h seg=%h dp=%b ft=%b need an=3f seg=7f dp=1 ft=0",
                     ifc.an, ifc.seg, ifc.dp, ifc.frame_tick);
        end
        repeat (2) @(posedge clk);
        #1 clr_n = 1'b1;
        k = 0;
        for (int i = 0; i < 6; i++) m_snap[i] = 4'h0;
        run_model(2, "post_reset");
        n_checks++;
        if (ifc.an !== 6'h3E) begin
            n_fail++;
            $display("FAIL restart_digit0 got an=%h need 3e", ifc.an);
        end
        run_model(FRAME * 2, "post_reset_frames");
    endtask

    task automatic test_lzb();
        logic [6:0] need5;
        int         seen5 = 0;
        int         seen4 = 0;
`ifdef SEG_SCAN_LZB_EN
        need5 = 7'h7F;
`else
        need5 = 7'h40;
`endif
        set_inputs(4'd0, 4'd5, 4'd1, 4'd2, 4'd3, 4'd4);
        run_model(FRAME, "lzb_load");
        for (int i = 0; i < FRAME; i++) begin
            run_model(1, "lzb_frame");
            if (ifc.an == 6'h1F) begin
                seen5++;
                n_checks++;
                if (ifc.seg !== need5) begin
                    n_fail++;
                    $display("FAIL lzb_digit5 got seg=%h need %h", ifc.seg, need5);
                end
            end
            if (ifc.an == 6'h2F) begin
                seen4++;
                n_checks++;
                if (ifc.seg !== 7'h12) begin
                    n_fail++;
                    $display("FAIL lzb_digit4 got seg=%h need 12", ifc.seg);
                end
            end
        end
        n_checks++;
        if (seen5 !== 3 || seen4 !== 3) begin
            n_fail++;
            $display("FAIL lzb_coverage got d5=%0d d4=%0d cycles need 3 each", seen5, seen4);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_scan_pattern();
        test_snapshot_midframe();
        test_blink();
        test_dash();
        test_random();
        test_reset_midframe();
        test_lzb();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got time limit reached need test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
